// File: rtl/vfifo_burst_scheduler.sv
// vfifo_burst_scheduler: external-memory burst sequencer for the AXI4-Stream virtual FIFO.
// Define VFIFO_FLUSH_EN to enable the idle-timeout flush of partial write bursts.
module vfifo_burst_scheduler #(
    parameter int          TDATA_BYTES  = 8,
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [63:0] BASE_ADDR    = 64'd0,
    parameter int          DEPTH_BEATS  = 4096,
    parameter int          BURST_LEN    = 16,
    parameter int          FIFO_DEPTH   = 64,
    parameter int          FLUSH_CYCLES = 64,
    localparam int         CW = $clog2(FIFO_DEPTH + 1),
    localparam int         LW = $clog2(DEPTH_BEATS + 1)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CW-1:0]         in_count,
    input  logic                  in_pop,
    input  logic [CW-1:0]         out_free,
    input  logic                  out_push,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    input  logic                  wr_done,
    input  logic [8:0]            wr_done_beats,
    output logic [LW-1:0]         mem_level,
    output logic                  mem_empty
);

    localparam int                    PW      = $clog2(DEPTH_BEATS);
    localparam logic [31:0]           LP_BL   = 32'(BURST_LEN);
    localparam logic [31:0]           LP_DEP  = 32'(DEPTH_BEATS);
    localparam logic [ADDR_WIDTH-1:0] LP_BASE = BASE_ADDR[ADDR_WIDTH-1:0];

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t          r_state;
    logic            r_last_wr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_mem_alloc;
    logic [LW-1:0]   r_mem_avail;
    logic [CW-1:0]   r_wr_pend;
    logic [CW-1:0]   r_rd_pend;

    logic [31:0]     w_wr_bnd;
    logic [31:0]     w_rd_bnd;
    logic [31:0]     w_wr_avail;
    logic [31:0]     w_wr_space;
    logic [31:0]     w_wr_len;
    logic [31:0]     w_rd_len;
    logic [31:0]     w_out_room;
    logic [31:0]     w_len;
    logic [PW-1:0]   w_ptr_sel;
    logic            w_full_ok;
    logic            w_flush_ok;
    logic            w_wr_elig;
    logic            w_rd_elig;
    logic            w_pick_wr;
    logic            w_load_wr;
    logic            w_load_rd;
    logic            w_flush_hit;

    // Increment/decrement netting that clamps at zero
    function automatic logic [31:0] f_net(input logic [31:0] cur,
                                          input logic [31:0] inc,
                                          input logic [31:0] dec);
        logic [31:0] sum;
        sum = cur + inc;
        return (sum < dec) ? 32'd0 : sum - dec;
    endfunction

    // Eligibility, burst length and round-robin grant for the next command
    always_comb begin
        w_wr_bnd   = LP_BL - (32'(r_wr_ptr) % LP_BL);
        w_rd_bnd   = LP_BL - (32'(r_rd_ptr) % LP_BL);
        w_wr_avail = (in_count > r_wr_pend) ? 32'(in_count) - 32'(r_wr_pend) : 32'd0;
        w_wr_space = LP_DEP - 32'(r_mem_alloc);
        w_out_room = (out_free > r_rd_pend) ? 32'(out_free) - 32'(r_rd_pend) : 32'd0;
        w_full_ok  = (w_wr_avail >= w_wr_bnd) && (w_wr_space >= w_wr_bnd);
        w_flush_ok = w_flush_hit && (w_wr_avail != 32'd0) &&
                     (w_wr_avail < w_wr_bnd) && (w_wr_space >= w_wr_avail);
        w_wr_elig  = w_full_ok || w_flush_ok;
        w_wr_len   = w_full_ok ? w_wr_bnd : w_wr_avail;
        w_rd_len   = (32'(r_mem_avail) < w_rd_bnd) ? 32'(r_mem_avail) : w_rd_bnd;
        w_rd_elig  = (r_mem_avail != '0) && (w_out_room >= w_rd_len);
        w_pick_wr  = w_wr_elig && (!w_rd_elig || !r_last_wr);
        w_load_wr  = (r_state == S_IDLE) && w_pick_wr;
        w_load_rd  = (r_state == S_IDLE) && w_rd_elig && !w_pick_wr;
        w_len      = w_load_wr ? w_wr_len : w_rd_len;
        w_ptr_sel  = w_load_wr ? r_wr_ptr : r_rd_ptr;
    end

`ifdef VFIFO_FLUSH_EN
    localparam int TW = $clog2(FLUSH_CYCLES + 2);

    logic [TW-1:0] r_flush_tmr;
    logic          w_flush_cond;

    assign w_flush_cond = (w_wr_avail != 32'd0) && (w_wr_avail < w_wr_bnd);
    assign w_flush_hit  = (32'(r_flush_tmr) >= 32'(FLUSH_CYCLES));

    // Idle timer for a stranded sub-burst tail; saturates at the timeout
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_flush_tmr <= '0;
        end else if (w_load_wr || !w_flush_cond) begin
            r_flush_tmr <= '0;
        end else if (!w_flush_hit) begin
            r_flush_tmr <= r_flush_tmr + 1'b1;
        end
    end
`else
    // No timer: a timeout can never be negative, so flush never fires
    assign w_flush_hit = (FLUSH_CYCLES < 0);
`endif

    // Command FSM with registered payload held stable until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_last_wr <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= LP_BASE;
            cmd_len   <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_load_wr || w_load_rd) begin
                        r_state   <= S_ISSUE;
                        r_last_wr <= w_load_wr;
                        cmd_valid <= 1'b1;
                        cmd_write <= w_load_wr;
                        cmd_addr  <= LP_BASE +
                                     ADDR_WIDTH'(32'(w_ptr_sel) * 32'(TDATA_BYTES));
                        cmd_len   <= 8'(w_len - 32'd1);
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        r_state   <= S_IDLE;
                        cmd_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Pointers advance by the burst length when a command is loaded
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_load_wr) r_wr_ptr <= PW'(32'(r_wr_ptr) + w_len);
            if (w_load_rd) r_rd_ptr <= PW'(32'(r_rd_ptr) + w_len);
        end
    end

    // Occupancy and in-flight counters with same-cycle netting
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mem_alloc <= '0;
            r_mem_avail <= '0;
            r_wr_pend   <= '0;
            r_rd_pend   <= '0;
        end else begin
            r_mem_alloc <= LW'(f_net(32'(r_mem_alloc),
                                     w_load_wr ? w_len : 32'd0,
                                     {31'd0, out_push}));
            r_mem_avail <= LW'(f_net(32'(r_mem_avail),
                                     wr_done ? 32'(wr_done_beats) : 32'd0,
                                     w_load_rd ? w_len : 32'd0));
            r_wr_pend   <= CW'(f_net(32'(r_wr_pend),
                                     w_load_wr ? w_len : 32'd0,
                                     {31'd0, in_pop}));
            r_rd_pend   <= CW'(f_net(32'(r_rd_pend),
                                     w_load_rd ? w_len : 32'd0,
                                     {31'd0, out_push}));
        end
    end

    assign mem_level = r_mem_alloc;
    assign mem_empty = (r_mem_alloc == '0) && (r_state == S_IDLE);

endmodule
